fetch_prefetch_unit: RTL and testbench

Parametrised successor to the single-PC instruction fetch stage. It runs its own PC sequencer against a synchronous instruction memory (1-cycle read latency) and buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO. It presents them to decode with a valid/ready handshake and supports branch/jump redirect with flush of stale fetches. It sits between instruction memory and the Main_Control/decode logic.

---
 rtl/fetch_prefetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// ============================================================================
// fetch_prefetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch stage with its own PC sequencer and a small prefetch FIFO.
// It issues sequential reads to a synchronous instruction memory with a
// 1-cycle read latency. Each returned word is paired with the PC that fetched
// it and queued for decode. A branch/jump redirect flushes the queue, kills
// any read still in flight, and restarts fetch at the new (word-aligned)
// target.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   imem_req          read request this cycle
//   imem_addr         read address (current fetch PC)
//   imem_rdata        read data, valid the cycle after imem_req
//   redirect_valid    restart the fetch stream at redirect_pc
//   redirect_pc       new fetch target (low two bits ignored)
//   out_valid         FIFO head holds a valid {pc, instr} pair
//   out_ready         decode accepts the head this cycle
//   out_instr/out_pc  head instruction and its PC
//   occupancy         number of valid FIFO entries
// ============================================================================
module fetch_prefetch_unit #(
   parameter int               XLEN     = 64,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int               PC_STEP  = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         imem_req,
   output logic [XLEN-1:0]              imem_addr,
   input  logic [31:0]                  imem_rdata,
   input  logic                         redirect_valid,
   input  logic [XLEN-1:0]              redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_instr,
   output logic [XLEN-1:0]              out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  inflight_pc;
   logic             inflight;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [OCC_W-1:0] count;
   logic [31:0]      instr_mem [DEPTH];
   logic [XLEN-1:0]  pc_mem    [DEPTH];

   logic             push;
   logic             pop;
   logic [OCC_W:0]   committed;
   logic             unused_redirect_low_bits;

   assign unused_redirect_low_bits = ^redirect_pc[1:0];

   // Issue and handshake decisions. A request is only issued when every
   // entry already queued plus the one in flight still leaves a free slot,
   // so the response always has somewhere to land. A pop in the same cycle
   // is deliberately not counted as a free slot. A redirect kills the
   // response arriving this cycle by suppressing its push.
   always_comb begin
      committed = {1'b0, count} + (OCC_W+1)'(inflight);
      imem_req  = !reset && !redirect_valid && (committed < (OCC_W+1)'(DEPTH));
      push      = inflight && !redirect_valid;
      pop       = out_valid && out_ready;
   end

   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign occupancy = count;
   assign out_instr = instr_mem[rd_ptr];
   assign out_pc    = pc_mem[rd_ptr];

   // PC sequencer, in-flight tracking and FIFO bookkeeping. Reset beats a
   // simultaneous redirect; a redirect empties the FIFO and drops the
   // in-flight read; otherwise the PC advances on each issue and the count
   // follows push/pop (a simultaneous push and pop leaves it unchanged).
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
         inflight    <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage has no reset; entries are only read while count says
   // they are valid.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         instr_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]    <= inflight_pc;
      end
   end

   // A push into a full FIFO without a matching pop would lose an entry;
   // the issue rule is meant to make this impossible.
   overflow_check : assert property (@(posedge clock) disable iff (reset)
      !(push && !pop && (count == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// ============================================================================
// tb_fetch_prefetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for fetch_prefetch_unit. A second instance with a
// reset PC near the top of the address space exercises PC wrap-around.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ============================================================================
module tb_fetch_prefetch_unit;

   localparam int DEPTH = 4;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic [2:0]  occupancy;

   logic        w_imem_req;
   logic [63:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic        w_out_valid;
   logic [31:0] w_out_instr;
   logic [63:0] w_out_pc;
   logic [2:0]  w_occupancy;

   int          vectors;
   int          miscompares;
   logic [31:0] salt;

   fetch_prefetch_unit #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(64'h0), .PC_STEP(4)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
   );

   fetch_prefetch_unit #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .PC_STEP(4)) dut_wrap (
      .clock(clock), .reset(reset),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .redirect_valid(1'b0), .redirect_pc(64'h0),
      .out_valid(w_out_valid), .out_ready(1'b1),
      .out_instr(w_out_instr), .out_pc(w_out_pc), .occupancy(w_occupancy)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Every address maps to a distinct word, so a word captured from the
   // wrong cycle shows up as a data miscompare.
   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[33:2] ^ {a[63:48], a[15:0]} ^ salt;
   endfunction

   // Instruction memories with one cycle of read latency.
   always @(posedge clock) begin
      if (imem_req) imem_rdata <= instr_of(imem_addr);
      if (w_imem_req) w_imem_rdata <= instr_of(w_imem_addr);
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input logic rst, input logic rv, input logic [63:0] rpc, input logic rdy);
      @(posedge clock);
      #1;
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic test_reset;
      do_reset(2);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
      do_reset(2);
      @(negedge clock);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid);
      end
      vectors++;
      if (occupancy !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy);
      end
      vectors++;
      if (imem_req !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_imem_req: got %0b expected 0", imem_req);
      end
   endtask

   task automatic test_sequential_fetch;
      do_reset(2);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
         @(negedge clock);
         if (c == 0) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
               miscompares++;
               $display("[TB] FAIL seq_first_req: got req=%0b addr=%0h expected req=1 addr=0", imem_req, imem_addr);
            end
         end
         if (c < 2) begin
            vectors++;
            if (out_valid !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL seq_latency c%0d: got out_valid=%0b expected 0", c, out_valid);
            end
         end else begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4*(c-2)) || out_instr !== instr_of(64'(4*(c-2)))) begin
               miscompares++;
               $display("[TB] FAIL seq_deliver c%0d: got v=%0b pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h",
                        c, out_valid, out_pc, out_instr, 4*(c-2), instr_of(64'(4*(c-2))));
            end
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset(2);
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
         @(negedge clock);
         if (c >= 4) begin
            vectors++;
            if (imem_req !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL bp_no_issue c%0d: got req=%0b expected 0", c, imem_req);
            end
         end
         if (c >= 5) begin
            vectors++;
            if (occupancy !== 3'd4) begin
               miscompares++;
               $display("[TB] FAIL bp_full c%0d: got occupancy=%0d expected 4", c, occupancy);
            end
         end
      end
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
         @(negedge clock);
         vectors++;
         if (out_valid !== 1'b1 || out_pc !== 64'(4*k)) begin
            miscompares++;
            $display("[TB] FAIL bp_drain k%0d: got v=%0b pc=%0h expected v=1 pc=%0h", k, out_valid, out_pc, 4*k);
         end
      end
   endtask

   task automatic test_redirect_flush;
      do_reset(2);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 64'h100, 1'b0);
      @(negedge clock);
      vectors++;
      if (occupancy !== 3'd3 || imem_req !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_pre: got occ=%0d req=%0b expected occ=3 req=0", occupancy, imem_req);
      end
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      @(negedge clock);
      vectors++;
      if (occupancy !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
         miscompares++;
         $display("[TB] FAIL flush_post: got occ=%0d v=%0b req=%0b addr=%0h expected occ=0 v=0 req=1 addr=100",
                  occupancy, out_valid, imem_req, imem_addr);
      end
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      @(negedge clock);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_killed: got v=%0b pc=%0h expected v=0", out_valid, out_pc);
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
         @(negedge clock);
         vectors++;
         if (out_valid !== 1'b1 || out_pc !== 64'h100 + 64'(4*k)) begin
            miscompares++;
            $display("[TB] FAIL flush_target k%0d: got v=%0b pc=%0h expected v=1 pc=%0h", k, out_valid, out_pc, 64'h100 + 64'(4*k));
         end
      end
   endtask

   task automatic test_back_to_back;
      do_reset(2);
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 64'h103, 1'b1);
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      @(negedge clock);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin
         miscompares++;
         $display("[TB] FAIL align: got req=%0b addr=%0h expected req=1 addr=100", imem_req, imem_addr);
      end
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 64'h200, 1'b1);
      applyStimulus(1'b0, 1'b1, 64'h300, 1'b1);
      @(negedge clock);
      vectors++;
      if (imem_req !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_no_issue: got req=%0b expected 0", imem_req);
      end
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
         @(negedge clock);
         if (c == 0) begin
            vectors++;
            if (imem_addr !== 64'h300 || imem_req !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL b2b_addr: got req=%0b addr=%0h expected req=1 addr=300", imem_req, imem_addr);
            end
         end
         if (c < 2) begin
            vectors++;
            if (out_valid !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL b2b_gap c%0d: got v=%0b pc=%0h expected v=0", c, out_valid, out_pc);
            end
         end else begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'h300 || out_instr !== instr_of(64'h300)) begin
               miscompares++;
               $display("[TB] FAIL b2b_first: got v=%0b pc=%0h instr=%0h expected v=1 pc=300 instr=%0h",
                        out_valid, out_pc, out_instr, instr_of(64'h300));
            end
         end
      end
   endtask

   task automatic test_pc_wrap;
      logic [63:0] expect_pc;
      do_reset(2);
      expect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
         @(negedge clock);
         if (c >= 2) begin
            vectors++;
            if (w_out_valid !== 1'b1 || w_out_pc !== expect_pc || w_out_instr !== instr_of(expect_pc)) begin
               miscompares++;
               $display("[TB] FAIL wrap c%0d: got v=%0b pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h",
                        c, w_out_valid, w_out_pc, w_out_instr, expect_pc, instr_of(expect_pc));
            end
            expect_pc = expect_pc + 64'd4;
         end
      end
   endtask

   task automatic test_reset_over_redirect;
      do_reset(2);
      for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
      @(negedge clock);
      vectors++;
      if (occupancy !== 3'd4) begin
         miscompares++;
         $display("[TB] FAIL rr_full: got occ=%0d expected 4", occupancy);
      end
      applyStimulus(1'b1, 1'b1, 64'h500, 1'b0);
      @(negedge clock);
      vectors++;
      if (imem_req !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rr_req_in_reset: got req=%0b expected 0", imem_req);
      end
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      @(negedge clock);
      vectors++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL rr_after: got v=%0b occ=%0d req=%0b addr=%0h expected v=0 occ=0 req=1 addr=0",
                  out_valid, occupancy, imem_req, imem_addr);
      end
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      @(negedge clock);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL rr_resume: got v=%0b pc=%0h expected v=1 pc=0", out_valid, out_pc);
      end
   endtask

   // Random traffic against a queue model: the FIFO is a queue of PCs, one
   // read may be outstanding, and the fetch PC restarts on redirect/reset.
   task automatic test_random;
      logic [63:0] mq[$];
      logic        m_inf;
      logic [63:0] m_ipc;
      logic [63:0] m_fpc;
      logic        r, rv, rdy, exp_req, exp_valid;
      logic [63:0] rpc;
      do_reset(2);
      mq.delete();
      m_inf = 1'b0;
      m_ipc = 64'h0;
      m_fpc = 64'h0;
      for (int n = 0; n < 500; n++) begin
         r   = ($urandom_range(0, 79) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = {$urandom, $urandom};
         rdy = ($urandom_range(0, 3) != 0);
         applyStimulus(r, rv, rpc, rdy);
         @(negedge clock);
         exp_req   = !r && !rv && ((mq.size() + int'(m_inf)) < DEPTH);
         exp_valid = (mq.size() != 0);
         vectors++;
         if (imem_req !== exp_req || (exp_req && imem_addr !== m_fpc)) begin
            miscompares++;
            $display("[TB] FAIL rand_req n%0d: got req=%0b addr=%0h expected req=%0b addr=%0h", n, imem_req, imem_addr, exp_req, m_fpc);
         end
         vectors++;
         if (out_valid !== exp_valid || occupancy !== 3'(mq.size())) begin
            miscompares++;
            $display("[TB] FAIL rand_occ n%0d: got v=%0b occ=%0d expected v=%0b occ=%0d", n, out_valid, occupancy, exp_valid, mq.size());
         end
         if (exp_valid) begin
            vectors++;
            if (out_pc !== mq[0] || out_instr !== instr_of(mq[0])) begin
               miscompares++;
               $display("[TB] FAIL rand_head n%0d: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                        n, out_pc, out_instr, mq[0], instr_of(mq[0]));
            end
         end
         if (r) begin
            mq.delete();
            m_inf = 1'b0;
            m_fpc = 64'h0;
         end else if (rv) begin
            mq.delete();
            m_inf = 1'b0;
            m_fpc = {rpc[63:2], 2'b00};
         end else begin
            if (exp_valid && rdy) void'(mq.pop_front());
            if (m_inf) mq.push_back(m_ipc);
            m_inf = exp_req;
            if (exp_req) begin
               m_ipc = m_fpc;
               m_fpc = m_fpc + 64'd4;
            end
         end
      end
   endtask

   // Test sequence.
   initial begin
      salt           = $urandom;
      vectors        = 0;
      miscompares    = 0;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      out_ready      = 1'b0;
      test_reset();
      test_sequential_fetch();
      test_backpressure();
      test_redirect_flush();
      test_back_to_back();
      test_pc_wrap();
      test_reset_over_redirect();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
